// File: rtl/manchester_receiver.sv
// Oversampling Manchester (biphase-level) receiver: recovers bits from mid-bit
// transitions, assembles an LSB-first word and flags timing violations.
module manchester_receiver #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             SerialIn,
    output logic [WIDTH-1:0] Rx,
    output logic             RxValid,
    output logic             RxError,
    output logic             Busy
);
    localparam int unsigned PW         = $clog2(2 * OVERSAMPLE) + 1;
    localparam int unsigned CW         = $clog2(WIDTH + 1);
    localparam int unsigned GLITCH_LIM = OVERSAMPLE / 4;
    localparam int unsigned MID_LO     = (3 * OVERSAMPLE) / 4;
    localparam int unsigned MID_HI     = (5 * OVERSAMPLE) / 4;
    localparam int unsigned PHASE_SAT  = 2 * OVERSAMPLE;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [PW-1:0]    phase_q, phase_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             bound_q, bound_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] rx_d;
    logic             valid_d, error_d, busy_d;

    logic             edge_c;
    logic             rise_c;
    logic [PW-1:0]    elapsed_c;

    // Line transitions seen after the synchroniser; elapsed counts the
    // current cycle so it equals cycles since the last mid-bit edge.
    assign edge_c    = s2_q ^ s3_q;
    assign rise_c    = s2_q & ~s3_q;
    assign elapsed_c = phase_q + PW'(1);

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= SerialIn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            bitcnt_q <= '0;
            bound_q  <= 1'b0;
            shift_q  <= '0;
            Rx       <= '0;
            RxValid  <= 1'b0;
            RxError  <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            bound_q  <= bound_d;
            shift_q  <= shift_d;
            Rx       <= rx_d;
            RxValid  <= valid_d;
            RxError  <= error_d;
            Busy     <= busy_d;
        end
    end

    // Next-state: classify each edge by its phase window, decode mid-bit edges
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        bound_d  = bound_q;
        shift_d  = shift_q;
        rx_d     = Rx;
        valid_d  = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d  = DATA;
                    phase_d  = '0;
                    bitcnt_d = '0;
                    bound_d  = 1'b0;
                end
            end
            DATA: begin
                if (phase_q != PW'(PHASE_SAT)) begin
                    phase_d = phase_q + PW'(1);
                end
                if (edge_c) begin
                    if (elapsed_c < PW'(GLITCH_LIM)) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else if (elapsed_c < PW'(MID_LO)) begin
                        // Only one bit-boundary edge is legal per bit
                        if (bound_q) begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bound_d = 1'b1;
                        end
                    end else if (elapsed_c <= PW'(MID_HI)) begin
                        shift_d            = shift_q >> 1;
                        shift_d[WIDTH-1]   = rise_c;
                        phase_d            = '0;
                        bound_d            = 1'b0;
                        bitcnt_d           = bitcnt_q + CW'(1);
                        if (bitcnt_q == CW'(WIDTH - 1)) begin
                            rx_d    = shift_d;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (elapsed_c > PW'(MID_HI)) begin
                    // Mid-bit edge missing: abandon the word
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DATA);
    end

endmodule

// File: tb/tb_manchester_receiver.sv
// Bench for manchester_receiver: directed and randomized frames from a
// cycle-level encoder, expectations from the frame timing rules.
module tb_manchester_receiver;
    localparam int N1 = 8;
    localparam int W1 = 16;
    localparam int N2 = 16;
    localparam int W2 = 8;

    logic          clock = 1'b0;
    logic          nreset, nreset2, ser1, ser2;
    logic [W1-1:0] rx1;
    logic          v1, e1, b1;
    logic [W2-1:0] rx2;
    logic          v2, e2, b2;

    manchester_receiver #(.WIDTH(W1), .OVERSAMPLE(N1)) dut (
        .clock(clock), .nreset(nreset), .SerialIn(ser1),
        .Rx(rx1), .RxValid(v1), .RxError(e1), .Busy(b1)
    );

    manchester_receiver #(.WIDTH(W2), .OVERSAMPLE(N2)) dut2 (
        .clock(clock), .nreset(nreset2), .SerialIn(ser2),
        .Rx(rx2), .RxValid(v2), .RxError(e2), .Busy(b2)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitors sampled on the falling edge
    int v1_cnt = 0, e1_cnt = 0, busy1_cnt = 0, v1_cyc = 0, e1_cyc = 0, both_cnt = 0;
    int v2_cnt = 0, e2_cnt = 0, v2_cyc = 0, e2_cyc = 0;
    always @(negedge clock) begin
        if (v1) begin v1_cnt <= v1_cnt + 1; v1_cyc <= cyc; end
        if (e1) begin e1_cnt <= e1_cnt + 1; e1_cyc <= cyc; end
        if (b1) busy1_cnt <= busy1_cnt + 1;
        if ((v1 && e1) || (v2 && e2)) both_cnt <= both_cnt + 1;
        if (v2) begin v2_cnt <= v2_cnt + 1; v2_cyc <= cyc; end
        if (e2) begin e2_cnt <= e2_cnt + 1; e2_cyc <= cyc; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int            n_pass = 0;
    int            n_checks = 0;
    int            gap_q[$];
    int            mid_cyc = 0;
    int            start_cyc = 0;
    logic [W1-1:0] ref_rx1 = '0;
    logic [W2-1:0] ref_rx2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Set the line level, then hold it for ncyc sampling edges
    task automatic drive(input int sel, input logic lvl, input int ncyc);
        if (sel == 0) ser1 = lvl; else ser2 = lvl;
        repeat (ncyc) begin @(posedge clock); #1; end
    endtask

    // Encoder: gap_q[i] = cycles between mid-bit edges (default n). A gap
    // beyond 5n/4 aborts the frame there; glitch_bit flips the line glitch_at
    // cycles after the preceding mid-bit edge and aborts.
    task automatic send_frame(input int sel, input logic [15:0] word, input int width,
                              input int n, input int nsend, input int glitch_bit,
                              input int glitch_at);
        logic prev, b;
        int   g;
        drive(sel, 1'b0, n / 2);
        drive(sel, 1'b1, 0);
        start_cyc = cyc;
        mid_cyc   = cyc;
        prev      = 1'b1;
        for (int i = 0; i < nsend; i++) begin
            b = word[i];
            g = (i < gap_q.size()) ? gap_q[i] : n;
            if (i == glitch_bit) begin
                drive(sel, prev, glitch_at);
                drive(sel, ~prev, n);
                drive(sel, 1'b0, 2 * n);
                return;
            end
            if (prev == b) begin
                drive(sel, prev, g / 2);
                drive(sel, ~b, g - g / 2);
            end else begin
                drive(sel, prev, g);
            end
            if (g > (5 * n) / 4) begin
                drive(sel, 1'b0, 2 * n);
                return;
            end
            drive(sel, b, 0);
            mid_cyc = cyc;
            prev    = b;
        end
        if (nsend == width) begin
            drive(sel, prev, n / 2);
            drive(sel, 1'b0, n);
        end
    endtask

    // A frame is accepted iff every mid-bit spacing lies within +-n/4 of n
    function automatic logic frame_ok(input int n);
        foreach (gap_q[i]) begin
            if (gap_q[i] < (3 * n) / 4 || gap_q[i] > (5 * n) / 4) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run1(input string tag, input logic [15:0] word);
        int   v0, e0, bz0;
        logic ok;
        ok  = frame_ok(N1);
        v0  = v1_cnt;
        e0  = e1_cnt;
        drive(0, 1'b0, N1);
        bz0 = busy1_cnt;
        send_frame(0, word, W1, N1, W1, -1, 0);
        if (ok) ref_rx1 = word;
        check($sformatf("%s.valid", tag), 32'(v1_cnt - v0), ok ? 32'd1 : 32'd0);
        check($sformatf("%s.error", tag), 32'(e1_cnt - e0), ok ? 32'd0 : 32'd1);
        check($sformatf("%s.rx", tag), 32'(rx1), 32'(ref_rx1));
        if (ok) begin
            check($sformatf("%s.latency", tag), 32'(v1_cyc - mid_cyc), 32'd3);
            check($sformatf("%s.busy", tag), 32'(busy1_cnt - bz0), 32'(mid_cyc - start_cyc));
        end else begin
            check($sformatf("%s.errlat", tag), 32'(e1_cyc - mid_cyc), 32'((5 * N1) / 4 + 1 + 3));
        end
    endtask

    task automatic run2(input string tag, input logic [7:0] word, input int gbit, input int gat);
        int   v0, e0;
        logic ok;
        ok = (gbit < 0);
        v0 = v2_cnt;
        e0 = e2_cnt;
        drive(1, 1'b0, N2);
        send_frame(1, {8'h00, word}, W2, N2, W2, gbit, gat);
        if (ok) ref_rx2 = word;
        check($sformatf("%s.valid", tag), 32'(v2_cnt - v0), ok ? 32'd1 : 32'd0);
        check($sformatf("%s.error", tag), 32'(e2_cnt - e0), ok ? 32'd0 : 32'd1);
        check($sformatf("%s.rx", tag), 32'(rx2), 32'(ref_rx2));
        if (ok) check($sformatf("%s.latency", tag), 32'(v2_cyc - mid_cyc), 32'd3);
        else    check($sformatf("%s.errlat", tag), 32'(e2_cyc - mid_cyc), 32'(gat + 3));
    endtask

    initial begin
        int   v0, e0, k, bad;
        logic [15:0] w;

        nreset = 1'b0; nreset2 = 1'b0; ser1 = 1'b0; ser2 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.rx", 32'(rx1), 32'd0);
        check("reset.valid", 32'(v1), 32'd0);
        check("reset.error", 32'(e1), 32'd0);
        check("reset.busy", 32'(b1), 32'd0);
        check("reset.rx2", 32'(rx2), 32'd0);
        check("reset.busy2", 32'(b2), 32'd0);
        nreset = 1'b1; nreset2 = 1'b1;
        drive(0, 1'b0, 4);

        // Ideal frame, back-to-back extremes
        gap_q.delete();
        run1("t1_a5c3", 16'hA5C3);
        check("t1.busy_len", 32'(mid_cyc - start_cyc), 32'(16 * N1));
        run1("t2_0000", 16'h0000);
        run1("t2_ffff", 16'hFFFF);

        // Jitter at the window edges, then one late mid-bit edge
        for (int i = 0; i < W1; i++) gap_q.push_back((i % 2 == 0) ? 6 : 10);
        run1("t3_jit", 16'h1234);
        gap_q[5] = 11;
        run1("t3_late", 16'h1234);

        // One-cycle glitch in IDLE
        gap_q.delete();
        v0 = v1_cnt; e0 = e1_cnt;
        drive(0, 1'b0, N1);
        k = cyc;
        drive(0, 1'b1, 1);
        drive(0, 1'b0, 2 * N1);
        check("t4.error", 32'(e1_cnt - e0), 32'd1);
        check("t4.valid", 32'(v1_cnt - v0), 32'd0);
        check("t4.errlat", 32'(e1_cyc - k), 32'd4);
        check("t4.busy", 32'(b1), 32'd0);
        check("t4.rx", 32'(rx1), 32'(ref_rx1));
        run1("t4_beef", 16'hBEEF);

        // Reset mid-frame
        v0 = v1_cnt; e0 = e1_cnt;
        drive(0, 1'b0, N1);
        send_frame(0, 16'hFFFF, W1, N1, 8, -1, 0);
        nreset = 1'b0;
        #1;
        ref_rx1 = '0;
        check("t5.rx_now", 32'(rx1), 32'd0);
        check("t5.busy_now", 32'(b1), 32'd0);
        drive(0, 1'b0, 3);
        nreset = 1'b1;
        drive(0, 1'b0, 2 * N1);
        check("t5.valid", 32'(v1_cnt - v0), 32'd0);
        check("t5.error", 32'(e1_cnt - e0), 32'd0);
        run1("t5_00ff", 16'h00FF);

        // Random words with random legal jitter
        for (int r = 0; r < 6; r++) begin
            gap_q.delete();
            for (int i = 0; i < W1; i++) gap_q.push_back(int'($urandom_range(6, 10)));
            w = 16'($urandom);
            run1($sformatf("rnd%0d", r), w);
        end
        // Random words with one late mid-bit edge
        for (int r = 0; r < 3; r++) begin
            gap_q.delete();
            for (int i = 0; i < W1; i++) gap_q.push_back(int'($urandom_range(6, 10)));
            bad = int'($urandom_range(0, W1 - 1));
            gap_q[bad] = 11;
            w = 16'($urandom);
            run1($sformatf("rnd_late%0d", r), w);
        end

        // WIDTH=8, OVERSAMPLE=16
        gap_q.delete();
        run2("t6_5a", 8'h5A, -1, 0);
        run2("t6_glitch", 8'hC3, 3, 3);
        for (int r = 0; r < 2; r++) begin
            w = 16'($urandom);
            run2($sformatf("t6_rnd%0d", r), w[7:0], -1, 0);
        end

        check("exclusive", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/manchester_receiver.md
Name: manchester_receiver

Overview:
Oversampling Manchester (biphase-level) decoder; the receive end of the team's Manchester serial link. Encoding: bit 1 is low then high, bit 0 is high then low, so every bit has a mid-bit transition. Frame format: idle line low, start bit '1', then WIDTH data bits LSB first, then line returns low. The block recovers each bit from mid-bit transitions, assembles the word and emits a one-cycle valid pulse, or an error pulse on timing violations.

Parameters:
WIDTH, 16, data bits per frame (start bit excluded)
OVERSAMPLE, 8, clock cycles per bit period N; multiple of 4, minimum 8

Ports:
clock  input  1  sampling clock, OVERSAMPLE times the bit rate
nreset  input  1  asynchronous active-low reset
SerialIn  input  1  Manchester line, asynchronous to clock
Rx  output  WIDTH  last good word; bit 0 is the first received data bit
RxValid  output  1  one-cycle pulse: Rx updated this cycle
RxError  output  1  one-cycle pulse: frame aborted
Busy  output  1  high while in DATA state

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (nreset). All flops clear. Rx=0, RxValid=0, RxError=0, Busy=0, state IDLE, synchroniser=0. Reset mid-frame discards the partial word, and no pulse follows.
- Input path: 2-flop synchroniser s1→s2, plus history flop s3. edge = s2^s3, rising = s2&~s3.
- Phase counter: counts cycles since the last mid-bit edge. Saturates at 2N. Width $clog2(2N)+1.
- IDLE: Busy=0. A rising edge is the start-bit mid-bit edge: phase←0, bitcnt←0, boundary flag←0, go to DATA. A falling edge is ignored.
- DATA: Busy=1. Phase increments each cycle. Edge windows by phase value at the edge:
  - phase < N/4: glitch. RxError pulse, go to IDLE.
  - N/4 ≤ phase < 3N/4: bit-boundary edge. Set boundary flag. A second boundary edge in the same bit is an error (RxError, go to IDLE).
  - 3N/4 ≤ phase ≤ 5N/4: mid-bit edge. Decoded bit = rising (1) or falling (0). Shift it into the shift register from the MSB side (LSB-first assembly). phase←0, boundary flag←0, bitcnt←bitcnt+1.
- No edge by phase = 5N/4+1: RxError pulse, go to IDLE, discard the word.
- Bit transitions: consecutive equal bits need a boundary edge, differing bits do not. The decoder does not check this consistency; it is enforced only through the window rules above.
- Frame completion: when the mid-bit edge brings bitcnt to WIDTH:
  - next cycle: Rx←shift register, RxValid=1 for exactly one cycle, state←IDLE;
  - the trailing falling boundary edge (last bit 1) arrives in IDLE and is ignored.
- Latency: RxValid rises at the 3rd rising clock edge after SerialIn makes the final mid-bit transition (2 synchroniser stages plus the decision register).
- Rx holds its value between frames. It is never modified on error.
- RxValid and RxError are mutually exclusive.
- Back-to-back frames need at least 1 idle-low bit period between the last data bit and the next start bit. A start bit is detected as soon as the FSM is in IDLE.
- Tolerance: mid-bit edges accepted within ±N/4 cycles of nominal. Single-sample line glitches during DATA produce RxError, never a wrong RxValid.

Test Plan:
1. WIDTH=16, OVERSAMPLE=8, ideal encoder sends 0xA5C3 → exactly one RxValid pulse, Rx=0xA5C3, RxValid 3 cycles after the last mid-bit edge, RxError never high, Busy high from start-bit detect until the valid cycle.
2. Frames 0x0000 then 0xFFFF separated by 1 idle bit (8 cycles low) → two RxValid pulses, Rx=0x0000 then 0xFFFF; the trailing boundary edge of 0xFFFF causes no error.
3. Jitter: mid-bit edges alternately at phase 6 and 10, word 0x1234 → Rx=0x1234 valid. Same word with one edge at phase 11 (line held 11 cycles) → RxError pulse at phase 11, no RxValid, Rx keeps the previous value.
4. Glitch: in IDLE, drive SerialIn high for 1 cycle → start detected, falling edge at phase 1 → RxError pulse, return to IDLE. A following clean frame 0xBEEF decodes correctly.
5. Reset mid-frame: assert nreset low after 8 data bits of 0xFFFF → Rx=0, Busy=0 immediately, no pulses. After release, a full frame 0x00FF gives Rx=0x00FF.
6. Parameter sweep: WIDTH=8, OVERSAMPLE=16, word 0x5A → Rx=0x5A. An edge at phase 3 (< N/4=4) mid-frame → RxError.
